spi_master: RTL and testbench

//   Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first. Sits upstream of the
//   spi_slave block and drives its cs/sck/mosi pins.

---
 rtl/spi_master.sv | 151 +++++++++++++++
 tb/tb_spi_master.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// Single-byte SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// SCK is divided down from clk; every output is registered.
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic [7:0] rx_data,
  output logic       busy,
  output logic       done,
  output logic       cs,
  output logic       sck,
  output logic       mosi,
  input  logic       miso
);

  // One shared counter times both the SCK half-periods and the CS gap.
  localparam int CNT_MAX = (CLK_DIV > CS_GAP) ? CLK_DIV : CS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CS_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_cnt_q, bit_cnt_d;
  logic [7:0]       shift_tx_q, shift_tx_d;
  logic [7:0]       shift_rx_q, shift_rx_d;
  logic [7:0]       rx_data_q, rx_data_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             cs_q, cs_d;
  logic             sck_q, sck_d;
  logic             mosi_q, mosi_d;
  logic             phase_end;

  assign phase_end = (state_q == GAP) ? (cnt_q == GAP_LAST) : (cnt_q == DIV_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      shift_tx_q <= '0;
      shift_rx_q <= '0;
      rx_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      cs_q       <= 1'b1;
      sck_q      <= 1'b0;
      mosi_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_tx_q <= shift_tx_d;
      shift_rx_q <= shift_rx_d;
      rx_data_q  <= rx_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      cs_q       <= cs_d;
      sck_q      <= sck_d;
      mosi_q     <= mosi_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SETUP;
      SETUP:   if (phase_end) state_d = HIGH;
      HIGH:    if (phase_end) state_d = (bit_cnt_q == 3'd7) ? HOLD : LOW;
      LOW:     if (phase_end) state_d = HIGH;
      HOLD:    if (phase_end) state_d = GAP;
      GAP:     if (phase_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d      = (state_q == IDLE || phase_end) ? '0 : cnt_q + 1'b1;
    bit_cnt_d  = bit_cnt_q;
    shift_tx_d = shift_tx_q;
    shift_rx_d = shift_rx_q;
    rx_data_d  = rx_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    cs_d       = cs_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          shift_tx_d = tx_data;
          cs_d       = 1'b0;
          mosi_d     = tx_data[7];
          busy_d     = 1'b1;
          bit_cnt_d  = 3'd0;
        end
      end
      SETUP, LOW: begin
        // miso is captured only on the edge that raises sck
        if (phase_end) begin
          sck_d      = 1'b1;
          shift_rx_d = {shift_rx_q[6:0], miso};
        end
      end
      HIGH: begin
        if (phase_end) begin
          sck_d = 1'b0;
          if (bit_cnt_q != 3'd7) begin
            bit_cnt_d  = bit_cnt_q + 3'd1;
            shift_tx_d = {shift_tx_q[6:0], 1'b0};
            mosi_d     = shift_tx_q[6];
          end
        end
      end
      HOLD: begin
        if (phase_end) begin
          cs_d      = 1'b1;
          rx_data_d = shift_rx_q;
          done_d    = 1'b1;
          mosi_d    = 1'b0;
        end
      end
      GAP: begin
        if (phase_end) busy_d = 1'b0;
      end
      default: ;
    endcase
  end

  assign rx_data = rx_data_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign cs      = cs_q;
  assign sck     = sck_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a behavioural SPI slave drives miso and
// collects mosi; frame timing is checked against the closed-form frame rules.
module tb_spi_master;

  localparam int D1 = 4;
  localparam int G1 = 4;
  localparam int D2 = 6;
  localparam int G2 = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       miso = 1'b0;
  logic [7:0] rx_data;
  logic       busy, done, cs, sck, mosi;

  logic       start2 = 1'b0;
  logic [7:0] tx_data2 = 8'h00;
  logic       miso2 = 1'b0;
  logic [7:0] rx_data2;
  logic       busy2, done2, cs2, sck2, mosi2;

  int checks = 0;
  int fails = 0;

  always #5 clk = ~clk;

  spi_master #(.CLK_DIV(D1), .CS_GAP(G1)) dut (
    .clk(clk), .reset(reset), .start(start), .tx_data(tx_data), .rx_data(rx_data),
    .busy(busy), .done(done), .cs(cs), .sck(sck), .mosi(mosi), .miso(miso)
  );

  spi_master #(.CLK_DIV(D2), .CS_GAP(G2)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .tx_data(tx_data2), .rx_data(rx_data2),
    .busy(busy2), .done(done2), .cs(cs2), .sck(sck2), .mosi(mosi2), .miso(miso2)
  );

  // Slave model and frame monitor for the default instance
  logic [7:0] slave_tx = 8'h00;
  logic [7:0] slave_shift = 8'h00;
  logic [7:0] slave_rx_last = 8'h00;
  logic [7:0] slave_rx_prev = 8'h00;
  int slave_idx = 7, pend = 0;
  int cur_rises = 0, last_rises = 0, cur_low = 0, last_low = 0;
  int cur_high = 0, last_high = 0, frames = 0;
  int done_total = 0, done_wide = 0, mosi_viol = 0, busy_falls = 0;
  int lat_cnt = 0, last_lat = 0;
  logic cs_p = 1'b1, sck_p = 1'b0, mosi_p = 1'b0, busy_p = 1'b0, done_p = 1'b0;

  always @(negedge clk) begin
    if (!cs && cs_p) begin
      last_high = cur_high;
      cur_high = 0;
      cur_low = 0;
      cur_rises = 0;
      slave_idx = 7;
      miso = slave_tx[7];
      pend = 0;
    end
    if (cs && !cs_p) begin
      last_low = cur_low;
      last_rises = cur_rises;
      slave_rx_prev = slave_rx_last;
      slave_rx_last = slave_shift;
      frames++;
      cur_high = 0;
    end
    if (!cs) cur_low++;
    else cur_high++;
    if (pend > 0) begin
      pend--;
      if (pend == 0 && slave_idx > 0) begin
        slave_idx--;
        miso = slave_tx[slave_idx];
      end
    end
    if (!cs && !sck_p && sck) begin
      cur_rises++;
      slave_shift = {slave_shift[6:0], mosi};
    end
    if (!cs && sck_p && !sck) pend = 2;
    if (sck && sck_p && (mosi !== mosi_p)) mosi_viol++;
    if (done) begin
      done_total++;
      if (done_p) done_wide++;
    end
    if (busy_p && !busy) busy_falls++;
    if (start && !busy) lat_cnt = 0;
    else lat_cnt++;
    if (done) last_lat = lat_cnt;
    cs_p = cs;
    sck_p = sck;
    mosi_p = mosi;
    busy_p = busy;
    done_p = done;
  end

  // Timing monitor for the CLK_DIV=6 instance
  int cur_low2 = 0, last_low2 = 0, cur_rises2 = 0, last_rises2 = 0;
  int first_rise2 = 0, since_rise2 = 0, period_bad2 = 0, lat_cnt2 = 0, last_lat2 = 0;
  logic cs2_p = 1'b1, sck2_p = 1'b0;

  always @(negedge clk) begin
    if (!cs2 && cs2_p) begin
      cur_low2 = 0;
      cur_rises2 = 0;
    end
    if (cs2 && !cs2_p) begin
      last_low2 = cur_low2;
      last_rises2 = cur_rises2;
    end
    if (!cs2) cur_low2++;
    since_rise2++;
    if (!cs2 && !sck2_p && sck2) begin
      if (cur_rises2 == 0) first_rise2 = cur_low2 - 1;
      else if (since_rise2 != 2 * D2) period_bad2++;
      since_rise2 = 0;
      cur_rises2++;
    end
    if (start2 && !busy2) lat_cnt2 = 0;
    else lat_cnt2++;
    if (done2) last_lat2 = lat_cnt2;
    cs2_p = cs2;
    sck2_p = sck2;
  end

  task automatic pulse_start(input logic [7:0] b);
    @(posedge clk); #1;
    start = 1'b1;
    tx_data = b;
    @(posedge clk); #1;
    start = 1'b0;
    tx_data = 8'($urandom);
  endtask

  task automatic wait_done(output bit to);
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (done) begin
        to = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_idle(output bit to);
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      if (!busy) begin
        to = 1'b0;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_rises(input int k, output bit to);
    to = 1'b1;
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk); #1;
      if (cur_rises >= k && !cs) begin
        to = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    start = 1'b1;
    tx_data = 8'($urandom);
    repeat (5) @(posedge clk);
    @(negedge clk);
    checks += 6;
    if (cs !== 1'b1) begin fails++; $display("[TB] FAIL reset_cs: got %b expected 1", cs); end
    if (sck !== 1'b0) begin fails++; $display("[TB] FAIL reset_sck: got %b expected 0", sck); end
    if (mosi !== 1'b0) begin fails++; $display("[TB] FAIL reset_mosi: got %b expected 0", mosi); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    if (done !== 1'b0) begin fails++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL reset_rx: got %h expected 00", rx_data); end
    @(posedge clk); #1;
    reset = 1'b1;
    start = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    checks += 4;
    if (cs !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_cs: got %b expected 1", cs); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_busy: got %b expected 0", busy); end
    if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL post_reset_rx: got %h expected 00", rx_data); end
    if (done_total !== 0) begin fails++; $display("[TB] FAIL post_reset_done: got %0d pulses expected 0", done_total); end
  endtask

  task automatic test_loopback;
    bit to;
    int d0;
    d0 = done_total;
    slave_tx = 8'h3C;
    pulse_start(8'hA5);
    wait_done(to);
    checks += 2;
    if (to) begin fails++; $display("[TB] FAIL loop_timeout: got no done expected done"); end
    if (rx_data !== 8'h3C) begin fails++; $display("[TB] FAIL loop_rx: got %h expected 3c", rx_data); end
    checks += 2;
    if (last_lat !== 17 * D1 + 1) begin fails++; $display("[TB] FAIL loop_latency: got %0d expected %0d", last_lat, 17 * D1 + 1); end
    if (last_low !== 17 * D1) begin fails++; $display("[TB] FAIL loop_cs_low: got %0d expected %0d", last_low, 17 * D1); end
    wait_idle(to);
    checks += 5;
    if (to) begin fails++; $display("[TB] FAIL loop_idle: got busy expected idle"); end
    if (done_total - d0 !== 1) begin fails++; $display("[TB] FAIL loop_done_cnt: got %0d expected 1", done_total - d0); end
    if (slave_rx_last !== 8'hA5) begin fails++; $display("[TB] FAIL loop_slave_rx: got %h expected a5", slave_rx_last); end
    if (last_rises !== 8) begin fails++; $display("[TB] FAIL loop_rises: got %0d expected 8", last_rises); end
    if (done_wide !== 0) begin fails++; $display("[TB] FAIL loop_done_width: got %0d wide pulses expected 0", done_wide); end
  endtask

  task automatic test_random_frames;
    bit to;
    logic [7:0] m, s;
    for (int i = 0; i < 6; i++) begin
      m = 8'($urandom);
      s = 8'($urandom);
      slave_tx = s;
      pulse_start(m);
      wait_done(to);
      checks += 4;
      if (to) begin fails++; $display("[TB] FAIL rand_timeout[%0d]: got no done expected done", i); end
      if (rx_data !== s) begin fails++; $display("[TB] FAIL rand_rx[%0d]: got %h expected %h", i, rx_data, s); end
      if (last_lat !== 17 * D1 + 1) begin fails++; $display("[TB] FAIL rand_latency[%0d]: got %0d expected %0d", i, last_lat, 17 * D1 + 1); end
      if (last_rises !== 8) begin fails++; $display("[TB] FAIL rand_rises[%0d]: got %0d expected 8", i, last_rises); end
      wait_idle(to);
      checks += 1;
      if (slave_rx_last !== m) begin fails++; $display("[TB] FAIL rand_slave_rx[%0d]: got %h expected %h", i, slave_rx_last, m); end
    end
    checks += 1;
    if (mosi_viol !== 0) begin fails++; $display("[TB] FAIL mosi_stable: got %0d changes while sck high expected 0", mosi_viol); end
  endtask

  task automatic test_back_to_back;
    bit to;
    int f0;
    logic [7:0] s1, s2;
    f0 = frames;
    s1 = 8'($urandom);
    s2 = 8'($urandom);
    slave_tx = s1;
    @(posedge clk); #1;
    start = 1'b1;
    tx_data = 8'h00;
    wait_done(to);
    tx_data = 8'hFF;
    slave_tx = s2;
    checks += 3;
    if (to) begin fails++; $display("[TB] FAIL b2b_timeout1: got no done expected done"); end
    if (rx_data !== s1) begin fails++; $display("[TB] FAIL b2b_rx1: got %h expected %h", rx_data, s1); end
    if (last_rises !== 8) begin fails++; $display("[TB] FAIL b2b_rises1: got %0d expected 8", last_rises); end
    wait_done(to);
    start = 1'b0;
    checks += 3;
    if (to) begin fails++; $display("[TB] FAIL b2b_timeout2: got no done expected done"); end
    if (rx_data !== s2) begin fails++; $display("[TB] FAIL b2b_rx2: got %h expected %h", rx_data, s2); end
    if (last_rises !== 8) begin fails++; $display("[TB] FAIL b2b_rises2: got %0d expected 8", last_rises); end
    wait_idle(to);
    repeat (12) @(negedge clk);
    #1;
    checks += 5;
    if (last_high < G1) begin fails++; $display("[TB] FAIL b2b_gap: got %0d cycles expected at least %0d", last_high, G1); end
    if (slave_rx_prev !== 8'h00) begin fails++; $display("[TB] FAIL b2b_slave_rx1: got %h expected 00", slave_rx_prev); end
    if (slave_rx_last !== 8'hFF) begin fails++; $display("[TB] FAIL b2b_slave_rx2: got %h expected ff", slave_rx_last); end
    if (frames - f0 !== 2) begin fails++; $display("[TB] FAIL b2b_frames: got %0d expected 2", frames - f0); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL b2b_idle: got %b expected 0", busy); end
  endtask

  task automatic test_ignore_start;
    bit to;
    int d0, b0, f0;
    logic [7:0] m, s;
    d0 = done_total;
    b0 = busy_falls;
    f0 = frames;
    m = 8'($urandom);
    s = 8'($urandom);
    slave_tx = s;
    pulse_start(m);
    wait_rises(3, to);
    checks += 1;
    if (to) begin fails++; $display("[TB] FAIL ign_rise_timeout: got no third rise expected one"); end
    start = 1'b1;
    tx_data = ~m;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(to);
    checks += 2;
    if (to) begin fails++; $display("[TB] FAIL ign_timeout: got no done expected done"); end
    if (rx_data !== s) begin fails++; $display("[TB] FAIL ign_rx: got %h expected %h", rx_data, s); end
    wait_idle(to);
    repeat (12) @(negedge clk);
    #1;
    checks += 4;
    if (done_total - d0 !== 1) begin fails++; $display("[TB] FAIL ign_done_cnt: got %0d expected 1", done_total - d0); end
    if (busy_falls - b0 !== 1) begin fails++; $display("[TB] FAIL ign_busy_cont: got %0d busy falls expected 1", busy_falls - b0); end
    if (slave_rx_last !== m) begin fails++; $display("[TB] FAIL ign_slave_rx: got %h expected %h", slave_rx_last, m); end
    if (frames - f0 !== 1) begin fails++; $display("[TB] FAIL ign_frames: got %0d expected 1", frames - f0); end
  endtask

  task automatic test_async_reset;
    bit to;
    int d0;
    logic [7:0] s;
    d0 = done_total;
    slave_tx = 8'($urandom);
    pulse_start(8'($urandom));
    wait_rises(4, to);
    checks += 1;
    if (to) begin fails++; $display("[TB] FAIL ares_rise_timeout: got no fourth rise expected one"); end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    checks += 5;
    if (cs !== 1'b1) begin fails++; $display("[TB] FAIL ares_cs: got %b expected 1", cs); end
    if (sck !== 1'b0) begin fails++; $display("[TB] FAIL ares_sck: got %b expected 0", sck); end
    if (busy !== 1'b0) begin fails++; $display("[TB] FAIL ares_busy: got %b expected 0", busy); end
    if (mosi !== 1'b0) begin fails++; $display("[TB] FAIL ares_mosi: got %b expected 0", mosi); end
    if (rx_data !== 8'h00) begin fails++; $display("[TB] FAIL ares_rx: got %h expected 00", rx_data); end
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checks += 1;
    if (done_total - d0 !== 0) begin fails++; $display("[TB] FAIL ares_no_done: got %0d pulses expected 0", done_total - d0); end
    s = 8'($urandom);
    slave_tx = s;
    pulse_start(8'h5A);
    wait_done(to);
    checks += 3;
    if (to) begin fails++; $display("[TB] FAIL ares_timeout: got no done expected done"); end
    if (rx_data !== s) begin fails++; $display("[TB] FAIL ares_rx_after: got %h expected %h", rx_data, s); end
    if (last_lat !== 17 * D1 + 1) begin fails++; $display("[TB] FAIL ares_latency: got %0d expected %0d", last_lat, 17 * D1 + 1); end
    wait_idle(to);
    checks += 1;
    if (slave_rx_last !== 8'h5A) begin fails++; $display("[TB] FAIL ares_slave_rx: got %h expected 5a", slave_rx_last); end
  endtask

  task automatic test_clk_div6;
    bit to;
    logic [7:0] exp_rx;
    for (int k = 0; k < 2; k++) begin
      miso2 = (k == 0);
      exp_rx = (k == 0) ? 8'hFF : 8'h00;
      @(posedge clk); #1;
      start2 = 1'b1;
      tx_data2 = 8'($urandom);
      @(posedge clk); #1;
      start2 = 1'b0;
      to = 1'b1;
      for (int n = 0; n < 3000; n++) begin
        @(negedge clk);
        if (done2) begin
          to = 1'b0;
          break;
        end
      end
      #1;
      checks += 6;
      if (to) begin fails++; $display("[TB] FAIL div6_timeout[%0d]: got no done expected done", k); end
      if (rx_data2 !== exp_rx) begin fails++; $display("[TB] FAIL div6_rx[%0d]: got %h expected %h", k, rx_data2, exp_rx); end
      if (last_lat2 !== 17 * D2 + 1) begin fails++; $display("[TB] FAIL div6_latency[%0d]: got %0d expected %0d", k, last_lat2, 17 * D2 + 1); end
      if (last_low2 !== 17 * D2) begin fails++; $display("[TB] FAIL div6_cs_low[%0d]: got %0d expected %0d", k, last_low2, 17 * D2); end
      if (first_rise2 !== D2) begin fails++; $display("[TB] FAIL div6_first_rise[%0d]: got %0d expected %0d", k, first_rise2, D2); end
      if (last_rises2 !== 8) begin fails++; $display("[TB] FAIL div6_rises[%0d]: got %0d expected 8", k, last_rises2); end
      repeat (G2 + 3) @(negedge clk);
    end
    checks += 2;
    if (period_bad2 !== 0) begin fails++; $display("[TB] FAIL div6_period: got %0d bad sck periods expected 0", period_bad2); end
    if (busy2 !== 1'b0) begin fails++; $display("[TB] FAIL div6_idle: got %b expected 0", busy2); end
  endtask

  initial begin
    $display("[TB] spi_master bench starting");
    test_reset();
    test_loopback();
    test_random_frames();
    test_back_to_back();
    test_ignore_start();
    test_async_reset();
    test_clk_div6();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
